// File: rtl/proc_xm_stage.sv
// proc_xm_stage: execute-to-memory boundary stage.
// Resolves conditional branches for the instruction in X and raises a fetch
// redirect when a branch is taken. Results enter a 2-entry skid buffer that
// drives M through a val/rdy handshake, so M backpressure never reaches X
// combinationally.
// Optional feature: define LAB2_PROC_XM_BR_COUNT_EN to add the 16-bit
// br_taken_cnt output, which counts taken (redirecting) branches.
module proc_xm_stage #(
  parameter int unsigned p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  // X side
  input  logic               x_val,
  output logic               x_rdy,
  input  logic [p_nbits-1:0] x_alu_out,
  input  logic               x_ops_eq,
  input  logic               x_ops_lt,
  input  logic               x_ops_ltu,
  input  logic [2:0]         x_br_type,
  input  logic [p_nbits-1:0] x_br_target,
  input  logic [4:0]         x_rd,
  input  logic               x_wen,
  // Fetch redirect
  output logic               redirect_val,
  output logic [p_nbits-1:0] redirect_target,
`ifdef LAB2_PROC_XM_BR_COUNT_EN
  output logic [15:0]        br_taken_cnt,
`endif
  // M side
  output logic               m_val,
  input  logic               m_rdy,
  output logic [p_nbits-1:0] m_result,
  output logic [4:0]         m_rd,
  output logic               m_wen
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  localparam logic [2:0] BrNone = 3'd0;
  localparam logic [2:0] BrBeq  = 3'd1;
  localparam logic [2:0] BrBne  = 3'd2;
  localparam logic [2:0] BrBlt  = 3'd3;
  localparam logic [2:0] BrBge  = 3'd4;
  localparam logic [2:0] BrBltu = 3'd5;
  localparam logic [2:0] BrBgeu = 3'd6;
  localparam logic [2:0] BrRsvd = 3'd7;

  state_e state_q, state_d;
  logic   head_q, tail_q;
  logic   x_rdy_q, m_val_q;

  logic               accept, dequeue, taken, entry_wen;
  logic [p_nbits-1:0] result_q [2];
  logic [4:0]         rd_q     [2];
  logic               wen_q    [2];

  assign accept  = x_val && x_rdy_q;
  assign dequeue = m_val_q && m_rdy;

  // Branch condition from the ALU comparison flags
  always_comb begin
    taken = 1'b0;
    unique case (x_br_type)
      BrBeq:   taken = x_ops_eq;
      BrBne:   taken = !x_ops_eq;
      BrBlt:   taken = x_ops_lt;
      BrBge:   taken = !x_ops_lt;
      BrBltu:  taken = x_ops_ltu;
      BrBgeu:  taken = !x_ops_ltu;
      default: taken = 1'b0;
    endcase
  end

  // Branches keep their slot for ordering but never write the register file
  assign entry_wen = x_wen && ((x_br_type == BrNone) || (x_br_type == BrRsvd));

  // Redirect only on acceptance, so a stalled branch is re-presented, not lost
  assign redirect_val    = accept && taken;
  assign redirect_target = x_br_target;

  // Buffer occupancy next-state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (accept) state_d = StOne;
      StOne: begin
        if (accept && !dequeue)      state_d = StTwo;
        else if (!accept && dequeue) state_d = StEmpty;
        else                         state_d = StOne;
      end
      StTwo:   if (dequeue) state_d = StOne;
      default: state_d = StEmpty;
    endcase
  end

  // Occupancy FSM, pointers and registered handshake outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StEmpty;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      x_rdy_q <= 1'b0;
      m_val_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept)  tail_q <= ~tail_q;
      if (dequeue) head_q <= ~head_q;
      x_rdy_q <= (state_d != StTwo);
      m_val_q <= (state_d != StEmpty);
    end
  end

  // Entry storage; contents are qualified by m_val so need no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      result_q[tail_q] <= x_alu_out;
      rd_q[tail_q]     <= x_rd;
      wen_q[tail_q]    <= entry_wen;
    end
  end

`ifdef LAB2_PROC_XM_BR_COUNT_EN
  logic [15:0] br_taken_cnt_q;

  // Count redirecting branches; wraps naturally at 16 bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      br_taken_cnt_q <= 16'h0000;
    end else if (redirect_val) begin
      br_taken_cnt_q <= br_taken_cnt_q + 16'h0001;
    end
  end

  assign br_taken_cnt = br_taken_cnt_q;
`endif

  assign x_rdy    = x_rdy_q;
  assign m_val    = m_val_q;
  assign m_result = result_q[head_q];
  assign m_rd     = rd_q[head_q];
  assign m_wen    = wen_q[head_q];

endmodule

// File: tb/tb_proc_xm_stage.sv
// Directed self-checking bench for proc_xm_stage.
// Define LAB2_PROC_XM_BR_COUNT_EN to also exercise br_taken_cnt.
module tb_proc_xm_stage;

  logic        clk;
  logic        reset;
  logic        x_val;
  logic        x_rdy;
  logic [31:0] x_alu_out;
  logic        x_ops_eq;
  logic        x_ops_lt;
  logic        x_ops_ltu;
  logic [2:0]  x_br_type;
  logic [31:0] x_br_target;
  logic [4:0]  x_rd;
  logic        x_wen;
  logic        redirect_val;
  logic [31:0] redirect_target;
  logic        m_val;
  logic        m_rdy;
  logic [31:0] m_result;
  logic [4:0]  m_rd;
  logic        m_wen;
`ifdef LAB2_PROC_XM_BR_COUNT_EN
  logic [15:0] br_taken_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  proc_xm_stage #(.p_nbits(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .x_val           (x_val),
    .x_rdy           (x_rdy),
    .x_alu_out       (x_alu_out),
    .x_ops_eq        (x_ops_eq),
    .x_ops_lt        (x_ops_lt),
    .x_ops_ltu       (x_ops_ltu),
    .x_br_type       (x_br_type),
    .x_br_target     (x_br_target),
    .x_rd            (x_rd),
    .x_wen           (x_wen),
    .redirect_val    (redirect_val),
    .redirect_target (redirect_target),
`ifdef LAB2_PROC_XM_BR_COUNT_EN
    .br_taken_cnt    (br_taken_cnt),
`endif
    .m_val           (m_val),
    .m_rdy           (m_rdy),
    .m_result        (m_result),
    .m_rd            (m_rd),
    .m_wen           (m_wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] rd,
                       input logic wen, input logic [2:0] bt, input logic eq,
                       input logic lt, input logic ltu, input logic [31:0] tgt);
    x_val       = v;
    x_alu_out   = res;
    x_rd        = rd;
    x_wen       = wen;
    x_br_type   = bt;
    x_ops_eq    = eq;
    x_ops_lt    = lt;
    x_ops_ltu   = ltu;
    x_br_target = tgt;
  endtask

  initial begin
    reset = 1'b0;
    m_rdy = 1'b1;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset state
    #12;
    check_eq("rst_m_val", {31'b0, m_val}, 32'd0);
    check_eq("rst_x_rdy", {31'b0, x_rdy}, 32'd0);
    check_eq("rst_redir", {31'b0, redirect_val}, 32'd0);
    reset = 1'b1;
    tick();
    check_eq("post_rst_x_rdy", {31'b0, x_rdy}, 32'd1);
    check_eq("post_rst_m_val", {31'b0, m_val}, 32'd0);

    // Plain ALU op
    drive(1'b1, 32'h8, 5'd5, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    check_eq("alu_no_redir", {31'b0, redirect_val}, 32'd0);
    tick();
    check_eq("alu_m_val", {31'b0, m_val}, 32'd1);
    check_eq("alu_m_result", m_result, 32'h8);
    check_eq("alu_m_rd", {27'b0, m_rd}, 32'd5);
    check_eq("alu_m_wen", {31'b0, m_wen}, 32'd1);

    // Taken beq while the previous op drains
    drive(1'b1, 32'h55, 5'd3, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 32'h200);
    #1;
    check_eq("beq_redir", {31'b0, redirect_val}, 32'd1);
    check_eq("beq_target", redirect_target, 32'h200);
    tick();
    check_eq("beq_m_val", {31'b0, m_val}, 32'd1);
    check_eq("beq_m_result", m_result, 32'h55);
    check_eq("beq_m_wen", {31'b0, m_wen}, 32'd0);

    // bge with lt=1: not taken
    drive(1'b1, 32'h66, 5'd4, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 32'h400);
    #1;
    check_eq("bge_no_redir", {31'b0, redirect_val}, 32'd0);
    tick();
    check_eq("bge_m_wen", {31'b0, m_wen}, 32'd0);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check_eq("drain_m_val", {31'b0, m_val}, 32'd0);

    // Backpressure: ops 1 and 2 accepted, bltu (result 3) held off
    m_rdy = 1'b0;
    drive(1'b1, 32'h1, 5'd1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check_eq("bp_x_rdy_one", {31'b0, x_rdy}, 32'd1);
    drive(1'b1, 32'h2, 5'd2, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check_eq("bp_x_rdy_two", {31'b0, x_rdy}, 32'd0);
    drive(1'b1, 32'h3, 5'd6, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 32'h300);
    #1;
    check_eq("bltu_stall_redir", {31'b0, redirect_val}, 32'd0);
    tick();
    check_eq("bp_hold_x_rdy", {31'b0, x_rdy}, 32'd0);
    check_eq("bp_hold_m_val", {31'b0, m_val}, 32'd1);
    check_eq("bp_head_1", m_result, 32'h1);
    check_eq("bp_hold_redir", {31'b0, redirect_val}, 32'd0);
    m_rdy = 1'b1;
    #1;
    check_eq("bp_rel_redir", {31'b0, redirect_val}, 32'd0);
    tick();
    check_eq("bp_head_2", m_result, 32'h2);
    check_eq("bp_rel_x_rdy", {31'b0, x_rdy}, 32'd1);
    check_eq("bltu_redir", {31'b0, redirect_val}, 32'd1);
    check_eq("bltu_target", redirect_target, 32'h300);
    tick();
    check_eq("bp_head_3_val", {31'b0, m_val}, 32'd1);
    check_eq("bp_head_3", m_result, 32'h3);
    check_eq("bp_head_3_wen", {31'b0, m_wen}, 32'd0);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check_eq("bp_drained", {31'b0, m_val}, 32'd0);

    // Asynchronous reset with two entries buffered
    m_rdy = 1'b0;
    drive(1'b1, 32'h10, 5'd10, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 32'h11, 5'd11, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check_eq("full_m_val", {31'b0, m_val}, 32'd1);
    check_eq("full_x_rdy", {31'b0, x_rdy}, 32'd0);
    drive(1'b1, 32'h12, 5'd12, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 32'h500);
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_m_val", {31'b0, m_val}, 32'd0);
    check_eq("arst_x_rdy", {31'b0, x_rdy}, 32'd0);
    check_eq("arst_redir", {31'b0, redirect_val}, 32'd0);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    m_rdy = 1'b1;
    #1;
    reset = 1'b1;
    tick();
    check_eq("rerst_x_rdy", {31'b0, x_rdy}, 32'd1);
    check_eq("rerst_m_val", {31'b0, m_val}, 32'd0);
    drive(1'b1, 32'h77, 5'd7, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check_eq("rerst_op_val", {31'b0, m_val}, 32'd1);
    check_eq("rerst_op_res", m_result, 32'h77);
    check_eq("rerst_op_rd", {27'b0, m_rd}, 32'd7);
    check_eq("rerst_op_wen", {31'b0, m_wen}, 32'd1);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();

`ifdef LAB2_PROC_XM_BR_COUNT_EN
    // Counter was cleared by the reset above; 3 taken, 2 not taken
    check_eq("cnt_zero", {16'b0, br_taken_cnt}, 32'd0);
    drive(1'b1, 32'h0, 5'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 32'h100); tick();
    drive(1'b1, 32'h0, 5'd0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 32'h100); tick();
    drive(1'b1, 32'h0, 5'd0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 32'h100); tick();
    drive(1'b1, 32'h0, 5'd0, 1'b0, 3'd6, 1'b0, 1'b0, 1'b1, 32'h100); tick();
    drive(1'b1, 32'h0, 5'd0, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0, 32'h100); tick();
    check_eq("cnt_three", {16'b0, br_taken_cnt}, 32'd3);
    // Run up to 0xFFFF, then one more taken branch wraps to zero
    drive(1'b1, 32'h0, 5'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 32'h100);
    for (int i = 0; i < 65532; i++) tick();
    check_eq("cnt_ffff", {16'b0, br_taken_cnt}, 32'hFFFF);
    tick();
    check_eq("cnt_wrap", {16'b0, br_taken_cnt}, 32'h0);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
